// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with valid/ready handshake, flush-to-bubble and a
// saturating stall counter. Define PIPE_STAGE_SKID_EN to build the skid entry (registered in_Ready).
module pipe_stage_reg #(
    parameter int                DATA_W     = 32,
    parameter int                CTRL_W     = 8,
    parameter logic [CTRL_W-1:0] FLUSH_CTRL = {CTRL_W{1'b0}},
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_Valid,
    output logic              in_Ready,
    input  logic [DATA_W-1:0] in_Data,
    input  logic [CTRL_W-1:0] in_Ctrl,
    input  logic              flush,
    output logic              out_Valid,
    input  logic              out_Ready,
    output logic [DATA_W-1:0] out_Data,
    output logic [CTRL_W-1:0] out_Ctrl,
    output logic [CNT_W-1:0]  out_StallCount
);

    logic              mValid;
    logic [DATA_W-1:0] mData;
    logic [CTRL_W-1:0] mCtrl;
    logic [CNT_W-1:0]  stallCount;
    logic              accept;
    logic              drain;

    assign accept = in_Valid & in_Ready;
    assign drain  = mValid & out_Ready;

    assign out_Valid      = mValid;
    assign out_Data       = mData;
    assign out_Ctrl       = mCtrl;
    assign out_StallCount = stallCount;

`ifdef PIPE_STAGE_SKID_EN
    logic              sValid;
    logic [DATA_W-1:0] sData;
    logic [CTRL_W-1:0] sCtrl;

    // Registered ready: depends only on skid occupancy, never on out_Ready.
    assign in_Ready = !sValid;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            mValid <= 1'b0;
            mData  <= '0;
            mCtrl  <= FLUSH_CTRL;
            sValid <= 1'b0;
            sData  <= '0;
            sCtrl  <= FLUSH_CTRL;
        end else if (flush) begin
            mValid <= 1'b0;
            mData  <= '0;
            mCtrl  <= FLUSH_CTRL;
            sValid <= 1'b0;
        end else if (sValid) begin
            // Skid always moves into the main entry before new input is taken.
            if (drain) begin
                mData  <= sData;
                mCtrl  <= sCtrl;
                sValid <= 1'b0;
            end
        end else if (!mValid || drain) begin
            if (accept) begin
                mValid <= 1'b1;
                mData  <= in_Data;
                mCtrl  <= in_Ctrl;
            end else begin
                mValid <= 1'b0;
                mCtrl  <= FLUSH_CTRL;
            end
        end else if (accept) begin
            sValid <= 1'b1;
            sData  <= in_Data;
            sCtrl  <= in_Ctrl;
        end
    end
`else
    assign in_Ready = !mValid | out_Ready;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            mValid <= 1'b0;
            mData  <= '0;
            mCtrl  <= FLUSH_CTRL;
        end else if (flush) begin
            mValid <= 1'b0;
            mData  <= '0;
            mCtrl  <= FLUSH_CTRL;
        end else if (!mValid || drain) begin
            if (accept) begin
                mValid <= 1'b1;
                mData  <= in_Data;
                mCtrl  <= in_Ctrl;
            end else begin
                mValid <= 1'b0;
                mCtrl  <= FLUSH_CTRL;
            end
        end
    end
`endif

    // Flush does not clear the counter; only reset does.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            stallCount <= '0;
        end else if (mValid && !out_Ready && (stallCount != {CNT_W{1'b1}})) begin
            stallCount <= stallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed literal checks plus randomized traffic against a
// queue-based model; a second instance with a 3-bit counter exercises saturation.
module tb_pipe_stage_reg;

    localparam int         DW = 32;
    localparam int         CW = 8;
    localparam logic [7:0] FC = 8'h00;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          clkEn = 1'b0;
    logic          reset = 1'b0;
    logic          in_Valid = 1'b0;
    logic          in_Ready;
    logic [DW-1:0] in_Data = '0;
    logic [CW-1:0] in_Ctrl = '0;
    logic          flush = 1'b0;
    logic          out_Valid;
    logic          out_Ready = 1'b0;
    logic [DW-1:0] out_Data;
    logic [CW-1:0] out_Ctrl;
    logic [15:0]   out_StallCount;

    logic          in_Ready3;
    logic          out_Valid3;
    logic [DW-1:0] out_Data3;
    logic [CW-1:0] out_Ctrl3;
    logic [2:0]    out_StallCount3;

    int passCount = 0;
    int checkCount = 0;
    bit running = 1'b0;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .FLUSH_CTRL(FC), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_Valid(in_Valid), .in_Ready(in_Ready),
        .in_Data(in_Data), .in_Ctrl(in_Ctrl), .flush(flush), .out_Valid(out_Valid),
        .out_Ready(out_Ready), .out_Data(out_Data), .out_Ctrl(out_Ctrl),
        .out_StallCount(out_StallCount)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .FLUSH_CTRL(FC), .CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .in_Valid(in_Valid), .in_Ready(in_Ready3),
        .in_Data(in_Data), .in_Ctrl(in_Ctrl), .flush(flush), .out_Valid(out_Valid3),
        .out_Ready(out_Ready), .out_Data(out_Data3), .out_Ctrl(out_Ctrl3),
        .out_StallCount(out_StallCount3)
    );

    always #5 clk = clkEn ? ~clk : clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checkCount++;
        if (got === want) passCount++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    endtask

    // Behavioural model: ordered list of held slots, oldest first.
    logic [DW-1:0] qData[$];
    logic [CW-1:0] qCtrl[$];
    logic [DW-1:0] heldData;
    int            cnt16;
    int            cnt3;

    function automatic bit modelInReady();
        if (CAP == 2) return qData.size() < 2;
        return (qData.size() == 0) || out_Ready;
    endfunction

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            qData.delete();
            qCtrl.delete();
            heldData = '0;
            cnt16 = 0;
            cnt3 = 0;
        end else begin
            bit rdy;
            rdy = modelInReady();
            if (qData.size() > 0 && !out_Ready) begin
                if (cnt16 < 65535) cnt16++;
                if (cnt3 < 7) cnt3++;
            end
            if (flush) begin
                qData.delete();
                qCtrl.delete();
                heldData = '0;
            end else begin
                if (qData.size() > 0 && out_Ready) begin
                    void'(qData.pop_front());
                    void'(qCtrl.pop_front());
                end
                if (in_Valid && rdy) begin
                    qData.push_back(in_Data);
                    qCtrl.push_back(in_Ctrl);
                end
            end
            if (qData.size() > 0) heldData = qData[0];
        end
    end

    // Compare process: mid-cycle, after inputs settle and well away from the falling edge.
    always @(posedge clk) begin
        #1;
        if (running && !reset) begin
            bit            expValid;
            logic [DW-1:0] expData;
            logic [CW-1:0] expCtrl;
            expValid = qData.size() > 0;
            expData  = expValid ? qData[0] : heldData;
            expCtrl  = expValid ? qCtrl[0] : FC;
            check("model_out_Valid", 64'(out_Valid), 64'(expValid));
            check("model_out_Data", 64'(out_Data), 64'(expData));
            check("model_out_Ctrl", 64'(out_Ctrl), 64'(expCtrl));
            check("model_in_Ready", 64'(in_Ready), 64'(modelInReady()));
            check("model_stall16", 64'(out_StallCount), 64'(cnt16));
            check("model_stall3", 64'(out_StallCount3), 64'(cnt3));
            check("model_dut3_valid", 64'(out_Valid3), 64'(expValid));
            check("model_dut3_data", 64'(out_Data3), 64'(expData));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit rdy, input bit fl);
        in_Valid  = v;
        in_Data   = d;
        in_Ctrl   = d[CW-1:0] | 8'h01;
        out_Ready = rdy;
        flush     = fl;
    endtask

    initial begin
        // Reset with no clock edge at all.
        #1;
        pulseReset();
        check("rst_out_Valid", 64'(out_Valid), 64'd0);
        check("rst_out_Ctrl", 64'(out_Ctrl), 64'(FC));
        check("rst_out_Data", 64'(out_Data), 64'd0);
        check("rst_stall", 64'(out_StallCount), 64'd0);
        check("rst_in_Ready", 64'(in_Ready), 64'd1);
        clkEn = 1'b1;
        running = 1'b1;

        // Streaming 1..8 with out_Ready high: each value one edge later, no gaps.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DW'(i), 1'b1, 1'b0);
            step();
            check("stream_valid", 64'(out_Valid), 64'd1);
            check("stream_data", 64'(out_Data), 64'(i));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check("stream_end_valid", 64'(out_Valid), 64'd0);
        check("stream_end_ctrl", 64'(out_Ctrl), 64'(FC));
        check("stream_end_hold", 64'(out_Data), 64'd8);

`ifdef PIPE_STAGE_SKID_EN
        pulseReset();
        drive(1'b1, 32'hA, 1'b1, 1'b0);
        step();
        check("skid_A_held", 64'(out_Data), 64'hA);
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        step();
        check("skid_A_still", 64'(out_Data), 64'hA);
        check("skid_in_Ready_low", 64'(in_Ready), 64'd0);
        drive(1'b1, 32'hC, 1'b0, 1'b0);
        step();
        step();
        check("skid_stall3", 64'(out_StallCount), 64'd3);
        check("skid_A_after_stall", 64'(out_Data), 64'hA);
        drive(1'b1, 32'hC, 1'b1, 1'b0);
        step();
        check("skid_B_out", 64'(out_Data), 64'hB);
        check("skid_ready_back", 64'(in_Ready), 64'd1);
        step();
        check("skid_C_out", 64'(out_Data), 64'hC);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check("skid_empty", 64'(out_Valid), 64'd0);

        pulseReset();
        drive(1'b1, 32'hA, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hD, 1'b0, 1'b1);
        step();
        check("flush_valid", 64'(out_Valid), 64'd0);
        check("flush_ctrl", 64'(out_Ctrl), 64'(FC));
        check("flush_in_Ready", 64'(in_Ready), 64'd1);
        check("flush_data", 64'(out_Data), 64'd0);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check("flush_D_dropped", 64'(out_Valid), 64'd0);
`else
        pulseReset();
        drive(1'b1, 32'hA, 1'b1, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        check("noskid_ready_low", 64'(in_Ready), 64'd0);
        out_Ready = 1'b1;
        #1;
        check("noskid_ready_comb", 64'(in_Ready), 64'd1);
        drive(1'b1, 32'hD, 1'b0, 1'b1);
        step();
        check("flush_valid", 64'(out_Valid), 64'd0);
        check("flush_ctrl", 64'(out_Ctrl), 64'(FC));
        check("flush_in_Ready", 64'(in_Ready), 64'd1);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check("flush_D_dropped", 64'(out_Valid), 64'd0);
`endif

        // Saturation: 3-bit counter stops at 7, 16-bit one keeps counting.
        pulseReset();
        drive(1'b1, 32'h55, 1'b1, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step();
        check("sat_cnt3", 64'(out_StallCount3), 64'd7);
        check("sat_cnt16", 64'(out_StallCount), 64'd10);
        step();
        check("sat_cnt3_hold", 64'(out_StallCount3), 64'd7);
        drive(1'b0, '0, 1'b0, 1'b1);
        step();
        check("flush_keeps_cnt", 64'(out_StallCount), 64'd12);

        // Randomized traffic, with phases of heavy and light backpressure.
        for (int i = 0; i < 3000; i++) begin
            int readyPct;
            readyPct = ((i / 300) % 2 == 0) ? 80 : 30;
            drive($urandom_range(0, 3) != 0, DW'($urandom),
                  $urandom_range(0, 99) < readyPct, $urandom_range(0, 24) == 0);
            in_Ctrl = CW'($urandom);
            if ($urandom_range(0, 399) == 0) pulseReset();
            step();
        end

        running = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
